// File: rtl/wishbone_ram_slave.sv
// rtl/wishbone_ram_slave.sv - Wishbone B3 classic single-beat RAM slave
// Word-addressed 32-bit RAM with byte lanes, configurable wait states, registered ack.

module wishbone_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [31:0]             lat_data;
  logic                    lat_we;
  logic [3:0]              lat_sel;

  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic                    commit_idle;
  logic                    commit_wait;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_data;
  logic                    acc_we;
  logic [3:0]              acc_sel;
  logic                    unused_addr_bits;

  assign req              = wishbone_cyc_i & wishbone_stb_i;
  assign in_idx           = wishbone_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{wishbone_addr_i[31:ADDR_WIDTH+2], wishbone_addr_i[1:0]};

  // commit marks the edge that enters ACK; with no wait states the live inputs are used directly
  assign commit_idle = (state == IDLE) && req && (WAIT_STATES == 0);
  assign commit_wait = (state == WAIT) && req && (cnt == 4'd0);
  assign commit      = commit_idle | commit_wait;

  assign acc_idx  = commit_idle ? in_idx          : lat_idx;
  assign acc_data = commit_idle ? wishbone_data_i : lat_data;
  assign acc_we   = commit_idle ? wishbone_we_i   : lat_we;
  assign acc_sel  = commit_idle ? wishbone_sel_i  : lat_sel;

  // RAM is never reset; a reset held low at the commit edge discards the write
  always_ff @(posedge clk) begin
    if (rst && commit && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      lat_idx         <= '0;
      lat_data        <= 32'd0;
      lat_we          <= 1'b0;
      lat_sel         <= 4'd0;
      wishbone_ack_o  <= 1'b0;
      wishbone_data_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          wishbone_ack_o  <= 1'b0;
          wishbone_data_o <= 32'd0;
          if (req) begin
            lat_idx  <= in_idx;
            lat_data <= wishbone_data_i;
            lat_we   <= wishbone_we_i;
            lat_sel  <= wishbone_sel_i;
            if (commit) begin
              state           <= ACK;
              wishbone_ack_o  <= 1'b1;
              wishbone_data_o <= acc_we ? 32'd0 : mem[acc_idx];
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (commit) begin
            state           <= ACK;
            wishbone_ack_o  <= 1'b1;
            wishbone_data_o <= acc_we ? 32'd0 : mem[acc_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          state           <= IDLE;
          wishbone_ack_o  <= 1'b0;
          wishbone_data_o <= 32'd0;
        end
        default: begin
          state           <= IDLE;
          wishbone_ack_o  <= 1'b0;
          wishbone_data_o <= 32'd0;
        end
      endcase
    end
  end

endmodule
